// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Summary  : Requester-side handshake bundle for ram_arbiter (two ports).
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int M = 8,
  parameter int A = 7
) ();
  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [A-1:0] addr0;
  logic [A-1:0] addr1;
  logic [M-1:0] wdata0;
  logic [M-1:0] wdata1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [M-1:0] rdata;
  logic         busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Summary  : Two-port arbiter and strobe sequencer for the shared single-port
//            RAM. Define RAM_ARB_RR_EN for round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int M = 8,
  parameter int A = 7
) (
  input  logic         clk1,
  input  logic         rst,
  ram_arbiter_if.slave bus,
  output logic         ram_act,
  output logic         ram_we,
  output logic         ram_d,
  output logic [A-1:0] ram_addr,
  inout  wire  [M-1:0] ram_data
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_owner;
  logic         r_we;
  logic [A-1:0] r_addr;
  logic [M-1:0] r_wdata;
  logic [M-1:0] r_rdata;

  logic w_any;
  logic w_pick;
  logic w_act;
  logic w_we;
  logic w_d;
  logic w_done;
  logic w_busy;

  assign w_any = bus.req0 | bus.req1;

`ifdef RAM_ARB_RR_EN
  // r_prefer names the requester that wins the next tie
  logic r_prefer;

  always_comb begin
    w_pick = bus.req1;
    if (bus.req0 && bus.req1) begin
      w_pick = r_prefer;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_prefer <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_prefer <= ~r_owner;
    end
  end
`else
  assign w_pick = ~bus.req0;
`endif

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_act  = 1'b0;
    w_we   = 1'b0;
    w_d    = 1'b0;
    w_done = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_any) begin
          w_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_act  = 1'b1;
        w_we   = r_we;
        w_next = r_we ? ST_STROBE : ST_CAPTURE;
      end
      ST_STROBE: begin
        w_act  = 1'b1;
        w_we   = r_we;
        w_d    = r_we;
        w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_act  = 1'b1;
        w_we   = r_we;
        w_next = ST_DONE;
      end
      ST_CAPTURE: begin
        w_act  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Command is captured once in IDLE; later req/we/addr changes are ignored
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_owner <= w_pick;
        r_we    <= w_pick ? bus.we1    : bus.we0;
        r_addr  <= w_pick ? bus.addr1  : bus.addr0;
        r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == ST_CAPTURE) begin
        r_rdata <= ram_data;
      end
    end
  end

  assign bus.gnt0  = w_busy & ~r_owner;
  assign bus.gnt1  = w_busy &  r_owner;
  assign bus.done0 = w_done & ~r_owner;
  assign bus.done1 = w_done &  r_owner;
  assign bus.rdata = r_rdata;
  assign bus.busy  = w_busy;

  assign ram_act  = w_act;
  assign ram_we   = w_we;
  assign ram_d    = w_d;
  assign ram_addr = r_addr;

  // The DONE cycle leaves the bus released so a following read never contends
  assign ram_data = w_we ? r_wdata : {M{1'bz}};

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencing controller and two-port arbiter for the shared single-port `ram` block. Two requesters (e.g. the CPU datapath and the I/O loader) issue word read/write requests. The block grants one at a time and drives the RAM's `act_ram`/`writeEn`/`d` strobes, address and tri-state data bus in a fixed multi-cycle sequence. Read data is registered and returned with a one-cycle `done` pulse.

## Interface
- `M`, 8, data word width (matches RAM `M`)
- `A`, 7, address width (matches RAM `A`)

- `clk1`  in  1  single system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req0`, `req1`  in  1  request from requester 0 / 1, level, held until `done`
- `we0`, `we1`  in  1  1 = write, 0 = read; held with `req`
- `addr0`, `addr1`  in  A  word address; held with `req`
- `wdata0`, `wdata1`  in  M  write data; held with `req`
- `gnt0`, `gnt1`  out  1  requester owns the RAM, SETUP through DONE inclusive
- `done0`, `done1`  out  1  one-cycle completion pulse
- `rdata`  out  M  registered read data, valid from the `done` cycle until the next read completes
- `busy`  out  1  state != IDLE
- `ram_act`  out  1  to RAM `act_ram`
- `ram_we`  out  1  to RAM `writeEn`
- `ram_d`  out  1  to RAM `d` (write strobe)
- `ram_addr`  out  A  to RAM `address_r`
- `ram_data`  inout  M  RAM data bus. Driven with the latched write data only while `ram_we`=1, otherwise `'z`

## Operation
- **States:**
  - IDLE
  - SETUP
  - STROBE (write only)
  - RELEASE (write only)
  - CAPTURE (read only)
  - DONE
- **IDLE:** if any `req` is high, latch the winner's `we`/`addr`/`wdata` into internal registers, set its `gnt`, and go to SETUP. Otherwise stay in IDLE.
- **SETUP:** `ram_act`=1, `ram_addr`=latched address, `ram_we`=latched we, `ram_d`=0. For a write, the bus is driven with latched data. Next state is STROBE for a write, CAPTURE for a read.
- **STROBE:** `ram_d`=1, all other signals held. Next state RELEASE.
- **RELEASE:** `ram_d`=0, `ram_we`/`ram_act`/address/data held. Next state DONE.
- **CAPTURE:** `ram_act`=1, `ram_we`=0, bus undriven. `rdata` <= `ram_data` at the end of this cycle. Next state DONE.
- **DONE:**
  - `ram_act`=0, `ram_we`=0, `ram_d`=0, bus released.
  - Granted requester's `done`=1, its `gnt` still 1. Next state IDLE.
  - `gnt` drops on entry to IDLE.
- Mid-transaction requests are ignored. The latched command completes even if `req` drops.
- A `req` still high in the IDLE cycle after DONE is treated as a new request. Requesters must drop `req` the cycle after `done` unless they want another access.
- `ram_addr` holds its last value in IDLE/DONE. Only `ram_act` qualifies it.
- `ram_we` and `ram_d` are never 1 while `ram_act`=0.
- **Reset:** `gnt*`, `done*`, `busy`, `ram_act`, `ram_we`, `ram_d` = 0. `rdata`, `ram_addr`, latched registers = 0. `ram_data` = `'z`. The RR pointer points at requester 0 (prefer 0 next). `rst` mid-transaction aborts on that edge; no `done` is issued and any partial write is the requester's problem.

## Timing
- Request seen high at IDLE edge N:
  - `gnt` high at N+1.
  - Write: `ram_d` pulse at N+2, `done` at N+4, IDLE at N+5.
  - Read: `done` and valid `rdata` at N+3, IDLE at N+4.
- Minimum request-to-request spacing: 5 cycles for a write, 4 for a read.
- `ram_data` is driven only in SETUP/STROBE/RELEASE of a write. The DONE cycle is the turnaround before any read.

## Configuration
- **`RAM_ARB_RR_EN` defined:** round-robin arbitration.
  - On a simultaneous request, the requester not served last wins.
  - The pointer updates in DONE.
  - A lone request always wins.
- **`RAM_ARB_RR_EN` undefined:** fixed priority, requester 0 always wins ties. Requester 1 can starve; no pointer register exists.

## Test plan
- **Write from requester 0:** `req0`=1, `we0`=1, `addr0`=0x05, `wdata0`=0xA5 at cycle 0.
  - `ram_d`=1 only at cycle 2, with `ram_data`=0xA5.
  - `done0` at cycle 4; RAM location 5 = 0xA5.
- **Read back from requester 1:** `req1` read `addr1`=0x05 → `done1` 3 cycles after acceptance, `rdata`=0xA5, `ram_data` never driven by the arbiter.
- **Simultaneous requests** (both write, from reset):
  - `RAM_ARB_RR_EN` on: grant order 0, 1, 0 over three back-to-back pairs.
  - Off: 0, 0, 0 while `req0` stays high.
- **Request drop mid-transaction:** drop `req0` in STROBE → transaction still completes, `done0` pulses at cycle 4.
- **Reset mid-write:** `rst` in STROBE → next cycle all outputs at reset values, `ram_data`=`'z`, no `done`; a new request afterward is served normally.
- **Bus contention check:** assertion across random traffic that the arbiter never drives `ram_data` while `ram_act`=1 and `ram_we`=0.
